// File: rtl/instr_word_encoder_loader_pkg.sv
// Shared types and field positions for the instruction word encoder/loader.
// The bit positions match what the control main decoder consumes.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'd0,
        OP_MEM = 2'd1,
        OP_BR  = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_e;

    localparam int OP_MSB     = 27;
    localparam int FUNCT5_BIT = 25;
    localparam int FUNCT0_BIT = 20;

    // Memory ops always use an immediate offset, pre-indexed, add, word, no writeback.
    localparam logic MEM_P = 1'b1;
    localparam logic MEM_U = 1'b1;
    localparam logic MEM_B = 1'b0;
    localparam logic MEM_W = 1'b0;

    typedef struct packed {
        logic [3:0]  cond;
        op_e         op;
        logic        i;
        logic [3:0]  cmd;
        logic        s;
        logic        load;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } fields_t;

endpackage

// File: rtl/instr_word_encoder_loader_if.sv
// Field-bundle handshake, instruction-memory write bus and session status.
// master drives the fields; slave is the encoder/loader.
interface instr_word_encoder_loader_if #(
    parameter int AW = 6
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [3:0]    in_cond;
    logic [1:0]    in_op;
    logic          in_i;
    logic [3:0]    in_cmd;
    logic          in_s;
    logic          in_load;
    logic [3:0]    in_rn;
    logic [3:0]    in_rd;
    logic [11:0]   in_src2;
    logic [23:0]   in_imm24;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          full;
    logic          err;

    modport master (
        output start, in_valid, in_last,
        output in_cond, in_op, in_i, in_cmd, in_s,
        output in_load, in_rn, in_rd, in_src2, in_imm24,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  busy, done, full, err
    );

    modport slave (
        input  start, in_valid, in_last,
        input  in_cond, in_op, in_i, in_cmd, in_s,
        input  in_load, in_rn, in_rd, in_src2, in_imm24,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output busy, done, full, err
    );

endinterface

// File: rtl/instr_word_encoder_loader_pack.sv
// Purely combinational field-to-word packer.
// Illegal ops yield a zero word and raise illegal_o.
module instr_word_pack
    import instr_enc_pkg::*;
(
    input  fields_t     f_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Place each field at the bit position the decoder expects.
    always_comb begin
        word_o              = '0;
        illegal_o           = 1'b0;
        word_o[31:28]       = f_i.cond;
        word_o[OP_MSB -: 2] = f_i.op;
        unique case (f_i.op)
            OP_DP: begin
                word_o[FUNCT5_BIT] = f_i.i;
                word_o[24:21]      = f_i.cmd;
                word_o[FUNCT0_BIT] = f_i.s;
                word_o[19:16]      = f_i.rn;
                word_o[15:12]      = f_i.rd;
                word_o[11:0]       = f_i.src2;
            end
            OP_MEM: begin
                word_o[FUNCT5_BIT] = 1'b0;
                word_o[24]         = MEM_P;
                word_o[23]         = MEM_U;
                word_o[22]         = MEM_B;
                word_o[21]         = MEM_W;
                word_o[FUNCT0_BIT] = f_i.load;
                word_o[19:16]      = f_i.rn;
                word_o[15:12]      = f_i.rd;
                word_o[11:0]       = f_i.src2;
            end
            OP_BR: begin
                word_o[25]   = 1'b1;
                word_o[24]   = 1'b0;
                word_o[23:0] = f_i.imm24;
            end
            OP_ILL: begin
                word_o    = '0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_word_encoder_loader.sv
// Accepts instruction field bundles and writes packed words to imem
// at consecutive addresses, one session per start pulse.
module instr_word_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instr_word_encoder_loader_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    fields_t       fld;
    logic [31:0]   word;
    logic          illegal;
    logic          ready;
    logic          accept;
    logic          hit_depth;

    assign fld = '{
        cond:  bus.in_cond,
        op:    op_e'(bus.in_op),
        i:     bus.in_i,
        cmd:   bus.in_cmd,
        s:     bus.in_s,
        load:  bus.in_load,
        rn:    bus.in_rn,
        rd:    bus.in_rd,
        src2:  bus.in_src2,
        imm24: bus.in_imm24
    };

    instr_word_pack u_pack (
        .f_i       (fld),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign ready     = (state_q == RUN) && (count_q < CW'(DEPTH));
    assign accept    = bus.in_valid && ready;
    assign hit_depth = !illegal && (count_q == CW'(DEPTH - 1));

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = (state_q == RUN) || (state_q == FLUSH);
    assign bus.done       = done_q;
    assign bus.full       = full_q;
    assign bus.err        = err_q;

    // Next-state and registered-output logic for the load session.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    count_d = '0;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = AW'(count_q);
                        wdata_d = word;
                        count_d = count_q + 1'b1;
                    end
                    if (hit_depth) begin
                        full_d = 1'b1;
                    end
                    if (bus.in_last || hit_depth) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        endcase
    end

    // Session state and write-port registers; reset drops any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

endmodule
